// File: rtl/pnd_scan_if.sv
`default_nettype none
// ============================================================================
// Module   : pnd_scan_if
// Purpose  : Host/detector-facing signal bundle of the prime-detector scanner.
// Revision : 1.0 - initial release
// ============================================================================
interface pnd_scan_if #(
    parameter int CNT_W = 4
);
    logic             start;
    logic [2:0]       lo;
    logic [2:0]       hi;
    logic [2:0]       d_out;
    logic             p_in;
    logic             busy;
    logic             res_valid;
    logic [2:0]       res_value;
    logic             res_prime;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] prime_count;
    logic [7:0]       prime_map;

    // Host/test side: issues requests and plays the detector.
    modport master (
        output start, lo, hi, p_in,
        input  d_out, busy, res_valid, res_value, res_prime,
               done, err, prime_count, prime_map
    );

    // Scan controller side.
    modport slave (
        input  start, lo, hi, p_in,
        output d_out, busy, res_valid, res_value, res_prime,
               done, err, prime_count, prime_map
    );
endinterface
`default_nettype wire

// File: rtl/pnd_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pnd_scan_ctrl
// Purpose  : Sweeps [lo, hi] through a 3-bit prime detector, streams results,
//            and accumulates a prime count and bitmap.
// Revision : 1.0 - initial release
// ============================================================================
module pnd_scan_ctrl #(
    parameter int DWELL = 1,
    parameter int CNT_W = 4
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    pnd_scan_if.slave    bus
);

    localparam logic [3:0]       c_DWELL_LAST = 4'(DWELL - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX    = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SAMPLE = 2'd2,
        S_FIN    = 2'd3
    } state_t;

    state_t           r_state;
    logic [2:0]       r_cur;
    logic [2:0]       r_hi;
    logic [3:0]       r_dwell;
    logic [2:0]       r_d_out;
    logic             r_busy;
    logic             r_res_valid;
    logic [2:0]       r_res_value;
    logic             r_res_prime;
    logic             r_done;
    logic             r_err;
    logic [CNT_W-1:0] r_prime_count;
    logic [7:0]       r_prime_map;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cur         <= 3'd0;
            r_hi          <= 3'd0;
            r_dwell       <= 4'd0;
            r_d_out       <= 3'd0;
            r_busy        <= 1'b0;
            r_res_valid   <= 1'b0;
            r_res_value   <= 3'd0;
            r_res_prime   <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_prime_count <= '0;
            r_prime_map   <= 8'd0;
        end else begin
            r_res_valid <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.lo <= bus.hi) begin
                            r_cur         <= bus.lo;
                            r_hi          <= bus.hi;
                            r_d_out       <= bus.lo;
                            r_dwell       <= 4'd0;
                            r_prime_count <= '0;
                            r_prime_map   <= 8'd0;
                            r_busy        <= 1'b1;
                            r_state       <= S_DRIVE;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end

                S_DRIVE: begin
                    // Capture on the edge that closes the dwell window: the
                    // strobe then coincides with SAMPLE (d_out still held),
                    // so the last strobe lands one cycle ahead of done.
                    if (r_dwell == c_DWELL_LAST) begin
                        r_res_value <= r_cur;
                        r_res_prime <= bus.p_in;
                        r_res_valid <= 1'b1;
                        if (bus.p_in) begin
                            if (r_prime_count != c_CNT_MAX)
                                r_prime_count <= r_prime_count + CNT_W'(1);
                            r_prime_map[r_cur] <= 1'b1;
                        end
                        r_state <= S_SAMPLE;
                    end else begin
                        r_dwell <= r_dwell + 4'd1;
                    end
                end

                S_SAMPLE: begin
                    // Compare before incrementing so hi = 7 terminates cleanly.
                    if (r_cur == r_hi) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_d_out <= 3'd0;
                        r_state <= S_FIN;
                    end else begin
                        r_cur   <= r_cur + 3'd1;
                        r_d_out <= r_cur + 3'd1;
                        r_dwell <= 4'd0;
                        r_state <= S_DRIVE;
                    end
                end

                S_FIN: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.d_out       = r_d_out;
    assign bus.busy        = r_busy;
    assign bus.res_valid   = r_res_valid;
    assign bus.res_value   = r_res_value;
    assign bus.res_prime   = r_res_prime;
    assign bus.done        = r_done;
    assign bus.err         = r_err;
    assign bus.prime_count = r_prime_count;
    assign bus.prime_map   = r_prime_map;

endmodule
`default_nettype wire
